pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Detects load-use hazards and taken branches.
//  Sequences multi-cycle data-memory accesses via a req/ready handshake.
//  Drives write-enables/flushes of PC, IF_ID, ID_EX, EX_MEM and a bubble-inject into MEM_WB (MEM_WB has no enable).
//  Keeps a saturating stall-cycle counter and a sticky memory-timeout error.
// PARAMETERS
//  TIMEOUT  16  max MEM_WAIT cycles before ERR (>=2)
//  CNT_W    32  width of stall_cycles counter
// PORTS
//  clk             in   1      clock; all state updates on posedge
//  rst             in   1      synchronous reset, active-high
//  ID_rs1Reg       in   5      rs1 of instruction in ID
//  ID_rs2Reg       in   5      rs2 of instruction in ID
//  EX_MemRead      in   1      instruction in EX is a load
//  EX_rdReg        in   5      rd of instruction in EX
//  EX_BranchTaken  in   1      branch/jump in EX resolved taken
//  MEM_MemRead     in   1      load in MEM
//  MEM_MemWrite    in   1      store in MEM
//  dmem_ready      in   1      data memory completes current access this cycle
//  dmem_req        out  1      data memory request
//  PC_Write        out  1      PC update enable
//  IF_ID_Write     out  1      IF_ID register enable
//  IF_ID_Flush     out  1      IF_ID clear to NOP
//  ID_EX_Write     out  1      ID_EX register enable
//  ID_EX_Flush     out  1      ID_EX control bits cleared (bubble)
//  EX_MEM_Write    out  1      EX_MEM register enable
//  WB_Bubble       out  1      forces MEM_WB RegWrite/MemtoReg inputs to 0
//  mem_err         out  1      sticky timeout error
//  stall_cycles    out  CNT_W  cycles with PC_Write=0 (saturating)
// BEHAVIOUR
//  State: RUN, MEM_WAIT, ERR (2-bit). Registered: state, wait_cnt, stall_cycles, mem_err. All control outputs are combinational from state+inputs.
//  Reset: state=RUN, wait_cnt=0, stall_cycles=0, mem_err=0. While rst=1: all *_Write=0, IF_ID_Flush=ID_EX_Flush=WB_Bubble=1, dmem_req=0.
//  mem_acc = MEM_MemRead|MEM_MemWrite. dmem_req = mem_acc in RUN/MEM_WAIT; 0 in ERR.
//  memstall = mem_acc & ~dmem_ready (RUN or MEM_WAIT). Access completing with ready=1 costs zero stall cycles.
//  Priority, highest first: ERR > memstall > branch > load-use > none.
//  memstall: PC/IF_ID/ID_EX/EX_MEM Write=0, no flushes, WB_Bubble=1. Branch or load-use in EX/ID is held and acted on once released.
//  branch (EX_BranchTaken): IF_ID_Flush=1, ID_EX_Flush=1; all Writes=1.
//  load-use: EX_MemRead & EX_rdReg!=0 & (EX_rdReg==ID_rs1Reg | EX_rdReg==ID_rs2Reg).
//    -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, others Write=1. One cycle per hazard.
//  none: all Writes=1, flushes/bubble=0.
//  RUN -> MEM_WAIT when memstall; wait_cnt<=1.
//  MEM_WAIT: ready=1 -> RUN, wait_cnt<=0.
//    ready=0 & wait_cnt==TIMEOUT-1 -> ERR, mem_err<=1.
//    else wait_cnt++.
//  ERR: all Writes=0, WB_Bubble=1, dmem_req=0; exit only via rst.
//  mem_acc dropping in MEM_WAIT (not legal upstream): treat as ready, return to RUN.
//  stall_cycles += 1 on each non-reset cycle with PC_Write=0 in RUN/MEM_WAIT. Holds at 2^CNT_W-1; frozen in ERR.
//  Reset mid-wait: next cycle RUN, counters cleared, no residual stall.
// STRUCTURE
//  pipe_ctrl_defs.vh: state encodings ST_RUN=0, ST_MEM_WAIT=1, ST_ERR=2; x0 register index constant.
//  Sub-module hazard_detect (combinational load-use compare), instantiated once. FSM, counters and output mux stay top-level.
// TESTING
//  1 Load x5 in EX, ID uses rs2=x5 -> exactly 1 cycle PC_Write=0, ID_EX_Flush=1; stall_cycles=1.
//  2 Load rd=x0 in EX, ID rs1=x0 -> no stall, all Writes=1.
//  3 MEM_MemRead=1, dmem_ready low 3 cycles then high -> 3 cycles WB_Bubble=1, Writes=0, state MEM_WAIT.
//    Then RUN; stall_cycles=3.
//  4 Branch taken in EX during 2-cycle memstall -> no flush while stalled; IF_ID_Flush=ID_EX_Flush=1 on release cycle.
//  5 TIMEOUT=4, ready never asserted -> ERR after 4 stall cycles, mem_err=1, dmem_req=0.
//    rst pulse -> RUN, mem_err=0.
//  6 CNT_W=4, force 20 stall cycles -> stall_cycles saturates at 15.
//    rst asserted in MEM_WAIT -> RUN, counters 0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StErr     = 2'd2
   } state_e;

   localparam logic [4:0] RegX0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by ID.
module pipeline_hazard_ctrl_hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   output logic       load_use
);

   // x0 is hardwired to zero, so a load targeting it never creates a dependency.
   assign load_use = ex_mem_read && (ex_rd != RegX0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle data-memory waits with timeout, and a saturating stall counter.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1Reg,
   input  logic [4:0]       ID_rs2Reg,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_rdReg,
   input  logic             EX_BranchTaken,
   input  logic             MEM_MemRead,
   input  logic             MEM_MemWrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Write,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Write,
   output logic             WB_Bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
   localparam logic [WaitW-1:0] WaitOne  = {{(WaitW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic               mem_err_q, mem_err_d;
   logic               mem_acc, memstall, load_use, stall_inc;

   pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
      .ex_mem_read (EX_MemRead),
      .ex_rd       (EX_rdReg),
      .id_rs1      (ID_rs1Reg),
      .id_rs2      (ID_rs2Reg),
      .load_use    (load_use)
   );

   assign mem_acc  = MEM_MemRead | MEM_MemWrite;
   assign memstall = mem_acc & ~dmem_ready & (state_q != StErr);

   // Memory stall dominates; a pending branch or load-use waits until release.
   always_comb begin
      dmem_req     = 1'b0;
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Write  = 1'b1;
      ID_EX_Flush  = 1'b0;
      EX_MEM_Write = 1'b1;
      WB_Bubble    = 1'b0;
      if (rst) begin
         {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
         {IF_ID_Flush, ID_EX_Flush, WB_Bubble}              = 3'b111;
      end else if (state_q == StErr) begin
         {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
         WB_Bubble = 1'b1;
      end else begin
         dmem_req = mem_acc;
         if (memstall) begin
            {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write} = 4'b0000;
            WB_Bubble = 1'b1;
         end else if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
         end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         StRun: begin
            if (memstall) begin
               state_d    = StMemWait;
               wait_cnt_d = WaitOne;
            end
         end
         StMemWait: begin
            // A dropped request is treated like completion.
            if (!memstall) begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WaitLast) begin
               state_d   = StErr;
               mem_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + WaitOne;
            end
         end
         StErr: ;
         default: begin
            state_d    = StRun;
            wait_cnt_d = '0;
         end
      endcase
   end

   assign stall_inc = ~PC_Write & (state_q != StErr);
   assign stall_d   = (stall_inc && (stall_q != {CNT_W{1'b1}})) ? stall_q + CntOne : stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         stall_q    <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         stall_q    <= stall_d;
         mem_err_q  <= mem_err_d;
      end
   end

   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level reference model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned TIMEOUT = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       id_rs1, id_rs2, ex_rd;
   logic             ex_memread, ex_br, mem_rd, mem_wr, ready;
   logic             dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, wb_bub, mem_err;
   logic [CNT_W-1:0] stall_cycles;

   int checks   = 0;
   int failures = 0;

   // Reference model state: consecutive stalled cycles of the current access,
   // error flag, and stall count.
   int m_k, m_err, m_cnt;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ID_rs1Reg      (id_rs1),
      .ID_rs2Reg      (id_rs2),
      .EX_MemRead     (ex_memread),
      .EX_rdReg       (ex_rd),
      .EX_BranchTaken (ex_br),
      .MEM_MemRead    (mem_rd),
      .MEM_MemWrite   (mem_wr),
      .dmem_ready     (ready),
      .dmem_req       (dmem_req),
      .PC_Write       (pc_w),
      .IF_ID_Write    (ifid_w),
      .IF_ID_Flush    (ifid_f),
      .ID_EX_Write    (idex_w),
      .ID_EX_Flush    (idex_f),
      .EX_MEM_Write   (exmem_w),
      .WB_Bubble      (wb_bub),
      .mem_err        (mem_err),
      .stall_cycles   (stall_cycles)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      ex_memread = 1'b0; ex_br = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ready = 1'b1;
   endtask

   // Expected {dmem_req, PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
   // ID_EX_Flush, EX_MEM_Write, WB_Bubble} from the priority rules.
   function automatic logic [7:0] expect_ctrl();
      logic acc, lu;
      acc = mem_rd | mem_wr;
      lu  = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
      if (rst)              return 8'b0_0010_101;
      if (m_err != 0)       return 8'b0_0000_001;
      if (acc && !ready)    return 8'b1_0000_001;
      if (ex_br)            return {acc, 7'b1111_110};
      if (lu)               return {acc, 7'b0001_110};
      return {acc, 7'b1101_010};
   endfunction

   // One clock: check outputs mid-cycle, then advance the model on the edge.
   task automatic step();
      logic [7:0] exp_v;
      logic       acc;
      exp_v = expect_ctrl();
      acc   = mem_rd | mem_wr;
      #1;
      check("ctrl", {dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, wb_bub}, exp_v);
      check("mem_err", mem_err, m_err);
      check("stall_cycles", stall_cycles, m_cnt);
      @(posedge clk);
      if (rst) begin
         m_k = 0; m_err = 0; m_cnt = 0;
      end else if (m_err == 0) begin
         if (!exp_v[6] && m_cnt < CNT_MAX) m_cnt++;
         if (acc && !ready) begin
            m_k++;
            if (m_k == TIMEOUT) m_err = 1;
         end else begin
            m_k = 0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      m_k = 0; m_err = 0; m_cnt = 0;
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      step();                                  // reset-state outputs
      rst = 1'b0;

      // Load-use on rs2: exactly one stall cycle.
      ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs1 = 5'd7;
      step();
      clear_inputs();
      step();
      check("t1_stall_count", stall_cycles, 1);

      // Load to x0 never stalls.
      ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
      step();
      check("t2_pc_write", pc_w, 1);
      clear_inputs();

      // Three-cycle memory wait.
      mem_rd = 1'b1; ready = 1'b0;
      repeat (3) step();
      ready = 1'b1;
      step();
      clear_inputs();
      step();
      check("t3_stall_count", stall_cycles, 4);

      // Branch held during a two-cycle memstall, flushed on release.
      mem_rd = 1'b1; ready = 1'b0; ex_br = 1'b1;
      repeat (2) step();
      ready = 1'b1;
      #1;
      check("t4_release_flush", {ifid_f, idex_f}, 2'b11);
      step();
      clear_inputs();

      // Saturation of the stall counter.
      ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
      repeat (20) step();
      check("t6_saturate", stall_cycles, CNT_MAX);
      clear_inputs();

      // Timeout into the error state, then recovery via reset.
      mem_wr = 1'b1; ready = 1'b0;
      repeat (6) step();
      check("t5_mem_err", mem_err, 1);
      check("t5_dmem_req", dmem_req, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_inputs();
      step();
      check("t5_err_cleared", mem_err, 0);

      // Reset asserted in the middle of a memory wait.
      mem_rd = 1'b1; ready = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      ready = 1'b1;
      step();
      check("t6_reset_mid_wait", stall_cycles, 0);
      clear_inputs();

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         rst        = ($urandom_range(0, 39) == 0);
         id_rs1     = 5'($urandom_range(0, 3));
         id_rs2     = 5'($urandom_range(0, 3));
         ex_rd      = 5'($urandom_range(0, 3));
         ex_memread = 1'($urandom_range(0, 1));
         ex_br      = ($urandom_range(0, 3) == 0);
         mem_rd     = ($urandom_range(0, 2) == 0);
         mem_wr     = ($urandom_range(0, 2) == 0);
         ready      = ($urandom_range(0, 9) < 7);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
